branch_history_table: RTL and testbench

//  Parametrised branch direction predictor for the MIPS core: a table of 2^INDEX_BITS saturating counters indexed by PC.
//  The fetch stage looks up a PC and gets a registered taken/not-taken prediction one cycle later.
//  The branch unit writes back the resolved outcome of every conditional branch (beq/bne/bz family).

---
 rtl/branch_history_table.sv | 140 ++++++++++++++
 tb/tb_branch_history_table.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_history_table.sv
// Branch direction predictor: 2^INDEX_BITS saturating counters indexed by
// word-aligned PC, registered lookup with write-first bypass, init sweep
// after reset and on flush.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_INIT | sweeping WEAK_NT into every entry; lookups/updates ignored
// S_RUN  | table valid; lookups served, updates train the counters
module branch_history_table #(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int PC_BITS    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                lookup_valid,
  input  logic [PC_BITS-1:0]  lookup_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [CTR_BITS-1:0] pred_ctr,
  input  logic                update_valid,
  input  logic [PC_BITS-1:0]  update_pc,
  input  logic                update_taken,
  output logic                ready
);

  localparam int ENTRIES = 2**INDEX_BITS;
  localparam logic [CTR_BITS-1:0]   WEAK_NT  = CTR_BITS'((2**(CTR_BITS-1)) - 1);
  localparam logic [CTR_BITS-1:0]   CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0]   CTR_ONE  = CTR_BITS'(1);
  localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                r_state;
  logic [INDEX_BITS-1:0] r_ptr;
  logic                  r_ready;
  logic                  r_pred_valid;
  logic                  r_pred_taken;
  logic [CTR_BITS-1:0]   r_pred_ctr;
  logic [CTR_BITS-1:0]   r_table [ENTRIES];

  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [INDEX_BITS-1:0] w_up_idx;
  logic [CTR_BITS-1:0]   w_up_cur;
  logic [CTR_BITS-1:0]   w_up_next;
  logic                  w_up_en;
  logic                  w_we;
  logic [INDEX_BITS-1:0] w_wr_idx;
  logic [CTR_BITS-1:0]   w_wr_val;
  logic                  w_bypass;
  logic [CTR_BITS-1:0]   w_lk_ctr;
  logic                  w_unused;

  assign w_lk_idx = lookup_pc[INDEX_BITS+1:2];
  assign w_up_idx = update_pc[INDEX_BITS+1:2];

  // Upper PC bits alias onto the same entry by design; byte offset is ignored.
  assign w_unused = ^{lookup_pc[PC_BITS-1:INDEX_BITS+2], lookup_pc[1:0],
                      update_pc[PC_BITS-1:INDEX_BITS+2], update_pc[1:0]};

  // Counter update, write-port select and same-index lookup bypass.
  always_comb begin
    w_up_cur  = r_table[w_up_idx];
    w_up_next = w_up_cur;
    if (update_taken) begin
      if (w_up_cur != CTR_MAX) w_up_next = w_up_cur + CTR_ONE;
    end else begin
      if (w_up_cur != '0) w_up_next = w_up_cur - CTR_ONE;
    end
    // A flush drops any update arriving in the same cycle.
    w_up_en  = (r_state == S_RUN) && update_valid && !flush;
    w_we     = (r_state == S_INIT) || w_up_en;
    w_wr_idx = (r_state == S_INIT) ? r_ptr : w_up_idx;
    w_wr_val = (r_state == S_INIT) ? WEAK_NT : w_up_next;
    w_bypass = w_up_en && (w_up_idx == w_lk_idx);
    w_lk_ctr = w_bypass ? w_up_next : r_table[w_lk_idx];
  end

  // Counter storage: no reset, contents come only from sweep and updates.
  always_ff @(posedge clk) begin
    if (w_we) r_table[w_wr_idx] <= w_wr_val;
  end

  // Sequencing FSM with registered ready and prediction outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_INIT;
      r_ptr        <= '0;
      r_ready      <= 1'b0;
      r_pred_valid <= 1'b0;
      r_pred_taken <= 1'b0;
      r_pred_ctr   <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (flush) begin
            r_ptr <= '0;
          end else if (r_ptr == LAST_IDX) begin
            r_state <= S_RUN;
            r_ptr   <= '0;
            r_ready <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_INIT;
            r_ptr   <= '0;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= S_INIT;
          r_ptr   <= '0;
          r_ready <= 1'b0;
        end
      endcase

      if ((r_state == S_RUN) && lookup_valid) begin
        r_pred_valid <= 1'b1;
        r_pred_ctr   <= w_lk_ctr;
        r_pred_taken <= w_lk_ctr[CTR_BITS-1];
      end else begin
        r_pred_valid <= 1'b0;
      end
    end
  end

  assign ready      = r_ready;
  assign pred_valid = r_pred_valid;
  assign pred_taken = r_pred_taken;
  assign pred_ctr   = r_pred_ctr;

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench: a 2-bit and a 3-bit counter instance share all stimulus.
module tb_branch_history_table;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;

  logic       v2, t2, rdy2;
  logic [1:0] c2;
  logic       v3, t3, rdy3;
  logic [2:0] c3;

  int n_tests = 0;
  int n_fail  = 0;

  int e2 [7] = '{2, 3, 3, 2, 1, 0, 0};
  int e3 [7] = '{4, 5, 6, 5, 4, 3, 2};
  int tk [7] = '{1, 1, 1, 0, 0, 0, 0};
  int s3 [5] = '{4, 5, 6, 7, 7};

  branch_history_table #(.INDEX_BITS(6), .CTR_BITS(2), .PC_BITS(32)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(v2), .pred_taken(t2), .pred_ctr(c2),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .ready(rdy2)
  );

  branch_history_table #(.INDEX_BITS(6), .CTR_BITS(3), .PC_BITS(32)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(v3), .pred_taken(t3), .pred_ctr(c3),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .ready(rdy3)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken);
    update_valid = 1'b1;
    update_pc    = pc;
    update_taken = taken;
    step();
    update_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [31:0] pc);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    step();
    lookup_valid = 1'b0;
  endtask

  // Counts cycles until ready rises; pred_valid must stay low meanwhile.
  task automatic wait_ready(input string tag, input int exp_n);
    int n;
    int pv_seen;
    n = 0;
    pv_seen = 0;
    while (!rdy2 && n < 300) begin
      step();
      n++;
      if (!rdy2 && (v2 || v3)) pv_seen++;
    end
    check({tag, "_cycles"}, n, exp_n);
    check({tag, "_rdy3"}, rdy3, 1);
    check({tag, "_pv_low"}, pv_seen, 0);
  endtask

  initial begin
    reset_n      = 1'b0;
    flush        = 1'b0;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h0040_0000;
    update_valid = 1'b0;
    update_pc    = '0;
    update_taken = 1'b0;
    repeat (3) step();

    check("rst_ready", {rdy2, rdy3}, 0);
    check("rst_pv", {v2, v3}, 0);
    check("rst_ctr", {t2, c2, t3, c3}, 0);

    // 1: init sweep with continuous lookups
    reset_n = 1'b1;
    check("init_ready0", rdy2, 0);
    wait_ready("init", 64);

    // 2: first lookup after init
    step();
    check("lk0_v", {v2, v3}, 2'b11);
    check("lk0_c2", c2, 1);
    check("lk0_t2", t2, 0);
    check("lk0_c3", c3, 3);
    check("lk0_t3", t3, 0);
    lookup_valid = 1'b0;
    step();
    check("idle_pv", {v2, v3}, 0);
    check("idle_hold", {c2, c3}, {2'd1, 3'd3});

    // 3: saturate up then down
    for (int i = 0; i < 7; i++) begin
      do_update(32'h0040_0008, tk[i][0]);
      do_lookup(32'h0040_0008);
      check($sformatf("sat_c2_%0d", i), c2, e2[i]);
      check($sformatf("sat_t2_%0d", i), t2, (e2[i] >= 2) ? 1 : 0);
      check($sformatf("sat_c3_%0d", i), c3, e3[i]);
      check($sformatf("sat_t3_%0d", i), t3, (e3[i] >= 4) ? 1 : 0);
    end
    for (int i = 0; i < 5; i++) begin
      do_update(32'h0040_000C, 1'b1);
      do_lookup(32'h0040_000C);
      check($sformatf("max_c3_%0d", i), c3, s3[i]);
    end
    check("max_c2", c2, 3);

    // 4: same-cycle bypass and independent indices
    update_valid = 1'b1; update_pc = 32'h0040_0010; update_taken = 1'b1;
    lookup_valid = 1'b1; lookup_pc = 32'h0040_0010;
    step();
    check("byp_c2", c2, 2);
    check("byp_t2", t2, 1);
    check("byp_c3", c3, 4);
    check("byp_t3", t3, 1);
    update_pc = 32'h0040_0014; lookup_pc = 32'h0040_0018;
    step();
    update_valid = 1'b0; lookup_valid = 1'b0;
    check("ind_lk_c2", c2, 1);
    check("ind_lk_c3", c3, 3);
    do_lookup(32'h0040_0014);
    check("ind_up_c2", c2, 2);
    check("ind_up_c3", c3, 4);

    // 5: aliasing through index 0, back-to-back updates
    do_update(32'h0000_0100, 1'b1);
    do_update(32'h0000_0100, 1'b1);
    do_lookup(32'h0000_0000);
    check("alias_c2", c2, 3);
    check("alias_c3", c3, 5);

    // 6: flush in RUN with a same-cycle update, updates during sweep
    flush = 1'b1;
    update_valid = 1'b1; update_pc = 32'h0000_0000; update_taken = 1'b0;
    step();
    flush = 1'b0;
    check("flush_ready0", {rdy2, rdy3}, 0);
    wait_ready("flush", 64);
    update_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      do_lookup(32'h0040_0000 + 32'(i * 4));
      check($sformatf("swept_c2_%0d", i), c2, 1);
      check($sformatf("swept_c3_%0d", i), c3, 3);
    end

    // flush while already sweeping restarts the pointer
    flush = 1'b1; step(); flush = 1'b0;
    repeat (30) step();
    flush = 1'b1; step(); flush = 1'b0;
    wait_ready("reflush", 64);

    // reset in the middle of a sweep
    do_lookup(32'h0040_0000);
    check("pre_rst_c", {c2, c3}, {2'd1, 3'd3});
    flush = 1'b1; step(); flush = 1'b0;
    repeat (19) step();
    reset_n = 1'b0;
    #1;
    check("midrst_ready", {rdy2, rdy3}, 0);
    check("midrst_ctr", {t2, c2, t3, c3}, 0);
    repeat (2) step();
    reset_n = 1'b1;
    wait_ready("midrst", 64);
    do_lookup(32'h0040_0014);
    check("after_rst_c2", c2, 1);
    check("after_rst_c3", c3, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
